gate_selftest_ctrl: RTL

Sequencer that runs an exhaustive functional self-test of the two-input basic-gate block (six outputs: AND, OR, NAND, NOR, XOR, XNOR). On a start request it drives the gate block's A/B inputs through all four input combinations and waits a programmable settle time for each. It then compares the six gate outputs against the golden truth table and accumulates per-gate and per-vector error results. It sits between a test/status master (start/abort/results) and one instance of the gate block, whose A/B inputs it owns while busy.

---
 rtl/gate_test_pkg.sv | 48 ++++
 rtl/gate_truth_rom.sv | 11 +
 rtl/gate_selftest_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and constants for the two-input basic-gate self-test sequencer.
// GATE_EXPECT is the golden truth table indexed by vec = {A, B}.
package gate_test_pkg;

    localparam int NUM_GATES   = 6;
    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = 2;
    localparam int CNT_W       = 4;
    localparam int ERR_CNT_W   = 5;
    localparam int POP_W       = 3;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NAND = 2;
    localparam int GATE_NOR  = 3;
    localparam int GATE_XOR  = 4;
    localparam int GATE_XNOR = 5;

    typedef enum logic [1:0] {
        GT_IDLE   = 2'd0,
        GT_SETTLE = 2'd1,
        GT_CHECK  = 2'd2,
        GT_DONE   = 2'd3
    } gt_state_e;

    typedef logic [NUM_GATES-1:0] gate_vec_t;

    // Builds one truth-table row so the bit placement follows the gate index constants.
    function automatic gate_vec_t gate_truth(input logic a, input logic b);
        gate_vec_t y;
        y            = '0;
        y[GATE_AND]  = a & b;
        y[GATE_OR]   = a | b;
        y[GATE_NAND] = ~(a & b);
        y[GATE_NOR]  = ~(a | b);
        y[GATE_XOR]  = a ^ b;
        y[GATE_XNOR] = ~(a ^ b);
        return y;
    endfunction

    localparam logic [NUM_VECTORS-1:0][NUM_GATES-1:0] GATE_EXPECT = {
        gate_truth(1'b1, 1'b1),
        gate_truth(1'b1, 1'b0),
        gate_truth(1'b0, 1'b1),
        gate_truth(1'b0, 1'b0)
    };

endpackage

// File: rtl/gate_truth_rom.sv
// Combinational lookup of the expected six gate outputs for input vector vec = {A, B}.
module gate_truth_rom
    import gate_test_pkg::*;
(
    input  logic [VEC_W-1:0]     vec_i,
    output logic [NUM_GATES-1:0] expect_o
);

    assign expect_o = GATE_EXPECT[vec_i];

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Exhaustive self-test sequencer for the two-input gate block: walks all four A/B
// vectors, waits a settle time per vector, and accumulates per-gate / per-vector errors.
module gate_selftest_ctrl
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic                 a_out,
    output logic                 b_out,
    input  logic [NUM_GATES-1:0] y_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] err_mask,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [NUM_VECTORS-1:0] fail_vec
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("gate_selftest_ctrl: SETTLE_CYCLES must be within 1..15");
    end

    localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC      = VEC_W'(NUM_VECTORS - 1);

    gt_state_e              state_q;
    logic [VEC_W-1:0]       vec_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   a_q, b_q;
    logic                   busy_q, done_q, pass_q;
    logic [NUM_GATES-1:0]   err_mask_q;
    logic [ERR_CNT_W-1:0]   err_count_q;
    logic [NUM_VECTORS-1:0] fail_vec_q;

    logic [NUM_GATES-1:0]   expected;
    logic [NUM_GATES-1:0]   mm;
    logic [POP_W-1:0]       mm_pop;
    logic [NUM_GATES-1:0]   err_mask_d;
    logic [ERR_CNT_W-1:0]   err_count_d;
    logic [NUM_VECTORS-1:0] fail_vec_d;
    logic [VEC_W-1:0]       vec_next;
    logic                   abort_run;

    gate_truth_rom u_rom (
        .vec_i    (vec_q),
        .expect_o (expected)
    );

    assign mm          = y_in ^ expected;
    assign err_mask_d  = err_mask_q | mm;
    assign err_count_d = err_count_q + ERR_CNT_W'(mm_pop);
    assign vec_next    = vec_q + VEC_W'(1);
    assign abort_run   = abort && (state_q == GT_SETTLE || state_q == GT_CHECK);

    always_comb begin
        mm_pop = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            mm_pop = mm_pop + POP_W'(mm[i]);
        end
    end

    // NOTE: every variable written in always_comb gets a full default first, so no latch is inferred.
    always_comb begin
        fail_vec_d        = fail_vec_q;
        fail_vec_d[vec_q] = |mm;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= GT_IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_mask_q  <= '0;
            err_count_q <= '0;
            fail_vec_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_run) begin
                // Partial results are kept; the CHECK update of this cycle is dropped.
                state_q <= GT_IDLE;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
                a_q     <= 1'b0;
                b_q     <= 1'b0;
            end else begin
                unique case (state_q)
                    GT_IDLE: begin
                        if (start) begin
                            state_q     <= GT_SETTLE;
                            vec_q       <= '0;
                            cnt_q       <= SETTLE_RELOAD;
                            a_q         <= 1'b0;
                            b_q         <= 1'b0;
                            busy_q      <= 1'b1;
                            pass_q      <= 1'b0;
                            err_mask_q  <= '0;
                            err_count_q <= '0;
                            fail_vec_q  <= '0;
                        end
                    end
                    GT_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= GT_CHECK;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    GT_CHECK: begin
                        err_mask_q  <= err_mask_d;
                        err_count_q <= err_count_d;
                        fail_vec_q  <= fail_vec_d;
                        if (vec_q == LAST_VEC) begin
                            state_q <= GT_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_d == '0);
                            a_q     <= 1'b0;
                            b_q     <= 1'b0;
                        end else begin
                            state_q      <= GT_SETTLE;
                            vec_q        <= vec_next;
                            cnt_q        <= SETTLE_RELOAD;
                            {a_q, b_q}   <= vec_next;
                        end
                    end
                    GT_DONE: begin
                        state_q <= GT_IDLE;
                    end
                    default: begin
                        state_q <= GT_IDLE;
                    end
                endcase
            end
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;
    assign fail_vec  = fail_vec_q;

endmodule
